// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register map, CTRL bit positions and dmem access-size encodings
package mmio_timer_pkg;

    // Register word indices (byte offset / 4)
    localparam logic [2:0] IDX_CTRL     = 3'd0;
    localparam logic [2:0] IDX_PRESCALE = 3'd1;
    localparam logic [2:0] IDX_COUNT    = 3'd2;
    localparam logic [2:0] IDX_COMPARE  = 3'd3;
    localparam logic [2:0] IDX_DUTY     = 3'd4;
    localparam logic [2:0] IDX_STATUS   = 3'd5;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;
    localparam int CTRL_PWM_EN     = 3;

    // funct3 encodings shared with memory and control
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    // Undefined funct3 values fall through to a word access
    function automatic size_e size_of(input logic [2:0] f3);
        return (f3 == F3_B || f3 == F3_BU) ? SZ_B :
               (f3 == F3_H || f3 == F3_HU) ? SZ_H : SZ_W;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// mmio_timer_if: core data-memory bus as seen by memory-mapped peripherals
interface mmio_timer_if;

    logic [2:0]  funct3;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;

    modport master (output funct3, dmem_wren, dmem_address, dmem_data_in, input dmem_data_out);
    modport slave  (input funct3, dmem_wren, dmem_address, dmem_data_in, output dmem_data_out);

endinterface

// File: rtl/mem_size_align.sv
// mem_size_align: byte/half/word lane merge for stores, shift/extend for loads, misalignment detect
module mem_size_align
    import mmio_timer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] st_old,
    input  logic [31:0] ld_word,
    output logic [31:0] st_merged,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    size_e       sz;
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] ld_shift;

    // Misaligned accesses get an empty lane mask, so stores leave the word untouched and loads read 0
    always_comb begin
        sz         = size_of(funct3);
        misaligned = (sz == SZ_H && addr_lo[0]) || (sz == SZ_W && addr_lo != 2'b00);
        sh         = {addr_lo, 3'b000};
        lane_mask  = misaligned   ? '0 :
                     sz == SZ_B   ? 32'h0000_00FF << sh :
                     sz == SZ_H   ? 32'h0000_FFFF << sh : '1;
        st_merged  = (st_old & ~lane_mask) | ((st_data << sh) & lane_mask);
        ld_shift   = ld_word >> sh;
        ld_data    = misaligned ? '0 :
                     sz == SZ_B ? {{24{ld_shift[7] & ~funct3[2]}}, ld_shift[7:0]} :
                     sz == SZ_H ? {{16{ld_shift[15] & ~funct3[2]}}, ld_shift[15:0]} : ld_shift;
    end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: dmem-mapped prescaled timer with compare/auto-reload, sticky match IRQ and PWM
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FFC0
)(
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq,
    output logic         pwm_out
);

    logic [3:0]  ctrl_q, ctrl_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] duty_q, duty_d;
    logic        match_q, match_d;
    logic        pwm_q, pwm_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit, wr, tick, hit_match, w1c, misaligned;
    logic [2:0]  idx;
    logic [31:0] rd_word, st_old, st_merged, ld_data;

    assign hit = bus.dmem_address[31:5] == BASE_ADDR[31:5];
    assign idx = bus.dmem_address[4:2];

    // Current value of the addressed register; STATUS merges against zero so untouched lanes never clear MATCH
    always_comb begin
        rd_word = '0;
        case (idx)
            IDX_CTRL:     rd_word = {28'd0, ctrl_q};
            IDX_PRESCALE: rd_word = {16'd0, prescale_q};
            IDX_COUNT:    rd_word = count_q;
            IDX_COMPARE:  rd_word = compare_q;
            IDX_DUTY:     rd_word = duty_q;
            IDX_STATUS:   rd_word = {31'd0, match_q};
            default:      rd_word = '0;
        endcase
        st_old = (idx == IDX_STATUS) ? '0 : rd_word;
    end

    mem_size_align u_align (
        .funct3     (bus.funct3),
        .addr_lo    (bus.dmem_address[1:0]),
        .st_data    (bus.dmem_data_in),
        .st_old     (st_old),
        .ld_word    (rd_word),
        .st_merged  (st_merged),
        .ld_data    (ld_data),
        .misaligned (misaligned)
    );

    // Timer progression first, then software writes override the fields they touch
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        count_d    = count_q;
        compare_d  = compare_q;
        duty_d     = duty_q;
        wr         = bus.dmem_wren && hit && !misaligned;
        tick       = ctrl_q[CTRL_EN] && pre_cnt_q == prescale_q;
        hit_match  = tick && count_q == compare_q;
        pre_cnt_d  = (ctrl_q[CTRL_EN] && !tick) ? pre_cnt_q + 16'd1 : '0;
        if (hit_match) begin
            if (ctrl_q[CTRL_AUTORELOAD])
                count_d = '0;
            else
                ctrl_d[CTRL_EN] = 1'b0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
        end
        w1c     = wr && idx == IDX_STATUS && st_merged[0];
        match_d = (match_q && !w1c) || hit_match;
        if (wr) begin
            case (idx)
                IDX_CTRL: begin
                    ctrl_d = st_merged[3:0];
                    if (!ctrl_q[CTRL_EN] && st_merged[CTRL_EN])
                        pre_cnt_d = '0;
                end
                IDX_PRESCALE: prescale_d = st_merged[15:0];
                IDX_COUNT: begin
                    count_d   = st_merged;
                    pre_cnt_d = '0;
                end
                IDX_COMPARE: compare_d = st_merged;
                IDX_DUTY:    duty_d    = st_merged;
                default: ;
            endcase
        end
        pwm_d   = ctrl_q[CTRL_PWM_EN] && ctrl_q[CTRL_EN] && count_q < duty_q;
        rdata_d = hit ? ld_data : '0;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            duty_q     <= '0;
            match_q    <= 1'b0;
            pwm_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            duty_q     <= duty_d;
            match_q    <= match_d;
            pwm_q      <= pwm_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.dmem_data_out = rdata_q;
    assign irq               = ctrl_q[CTRL_IRQ_EN] & match_q;
    assign pwm_out           = pwm_q;

endmodule
